// File: rtl/wb_tag_arb_pkg.sv
// wb_tag_arb_pkg: arbiter FSM state encoding and watchdog/expiry counter width
package wb_tag_arb_pkg;
   typedef enum logic {IDLE, OWNED} arb_state_t;
   localparam int TO_W = 16;
endpackage

// File: rtl/wb_tag_rr_pick.sv
// wb_tag_rr_pick: combinational rotate-priority encoder, first requester after last wins
// ports: req (candidates), last (previous owner) -> onehot, idx (winner), any (some request)
module wb_tag_rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         any
);
   // walk from furthest to nearest rotation slot so the nearest hit is written last
   always_comb begin
      onehot = '0;
      idx = '0;
      any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         int p;
         p = (int'(last) + k) % N;
         if (req[p]) begin
            onehot = '0;
            onehot[p] = 1'b1;
            idx = W'(p);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_tag_target_arbiter.sv
// wb_tag_target_arbiter: round-robin Wishbone target arbiter with cyc lock and ack watchdog
// ports: clock, reset_n (async assert, synchronised release); req/i_cyc per initiator;
//        t_ack/t_err from target; gnt/gnt_valid/target_initiator grant; timeout_err pulse,
//        timeout_cnt saturating expiry count
module wb_tag_target_arbiter
   import wb_tag_arb_pkg::*;
#(
   parameter int N_INITIATORS   = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDX_WIDTH      = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [N_INITIATORS-1:0] req,
   input  logic                    t_ack,
   input  logic                    t_err,
   input  logic [N_INITIATORS-1:0] i_cyc,
   output logic [N_INITIATORS-1:0] gnt,
   output logic                    gnt_valid,
   output logic [IDX_WIDTH-1:0]    target_initiator,
   output logic                    timeout_err,
   output logic [TO_W-1:0]         timeout_cnt
);
   arb_state_t state, state_nxt;
   logic armed;
   logic [IDX_WIDTH-1:0] owner, owner_nxt, last_owner, last_nxt, pick_idx;
   logic [N_INITIATORS-1:0] eff_req, pick_hot, gnt_q, gnt_nxt;
   logic [TO_W-1:0] wd, wd_nxt, tcnt, tcnt_nxt;
   logic pick_any, owned, term, expire;
   assign eff_req = req & i_cyc;
   assign owned = state == OWNED;
   assign term = t_ack | t_err;
   assign expire = owned && TIMEOUT_CYCLES != 0 && wd == TO_W'(TIMEOUT_CYCLES) && !term;
   wb_tag_rr_pick #(.N(N_INITIATORS), .W(IDX_WIDTH)) u_pick (
      .req(eff_req), .last(last_owner), .onehot(pick_hot), .idx(pick_idx), .any(pick_any)
   );
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt = last_owner;
      gnt_nxt = gnt_q;
      wd_nxt = '0;
      tcnt_nxt = tcnt;
      if (!owned) begin
         state_nxt = pick_any ? OWNED : IDLE;
         owner_nxt = pick_any ? pick_idx : owner;
         gnt_nxt = pick_hot;
      end else begin
         wd_nxt = (term || expire) ? '0 : eff_req[owner] ? wd + 1'b1 : wd;
         tcnt_nxt = (expire && tcnt != '1) ? tcnt + 1'b1 : tcnt;
         if (!i_cyc[owner]) begin
            state_nxt = IDLE;
            last_nxt = owner;
            gnt_nxt = '0;
         end
      end
   end
   // armed delays the first functional edge by one so release is clock-synchronous
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         armed <= 1'b0;
         state <= IDLE;
         owner <= '0;
         last_owner <= IDX_WIDTH'(N_INITIATORS - 1);
         gnt_q <= '0;
         wd <= '0;
         tcnt <= '0;
      end else begin
         armed <= 1'b1;
         if (armed) begin
            state <= state_nxt;
            owner <= owner_nxt;
            last_owner <= last_nxt;
            gnt_q <= gnt_nxt;
            wd <= wd_nxt;
            tcnt <= tcnt_nxt;
         end
      end
   end
   assign gnt = gnt_q;
   assign gnt_valid = owned;
   assign target_initiator = owned ? owner : '0;
   assign timeout_err = expire;
   assign timeout_cnt = tcnt;
endmodule
